// File: rtl/voice_rec_play_ctrl.sv
// Record/playback sequencer: drives the ADC capture block into SDRAM, then replays the
// stored take with one SDRAM read request per DAC LRCLK half-frame.
module voice_rec_play_ctrl #(
  parameter int ADDR_W      = 22,
  parameter int REC_WORDS   = 960000,
  parameter int LOAD_CYCLES = 16
) (
  input  logic              clock_50M,
  input  logic              reset,
  input  logic              key_record,
  input  logic              key_play,
  input  logic              wav_wren,
  input  logic              dacclk,
  output logic              wr_load,
  output logic              record_start,
  output logic              voice_write_done,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              rd_load,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] rec_len,
  output logic [2:0]        state
);

  localparam int CNT_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  LOAD_LAST = CNT_W'(LOAD_CYCLES - 1);
  localparam logic [ADDR_W-1:0] WR_LAST   = ADDR_W'(REC_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REC_LOAD  = 3'd1,
    RECORD    = 3'd2,
    REC_DONE  = 3'd3,
    PLAY_LOAD = 3'd4,
    PLAY      = 3'd5
  } state_t;

  state_t           fsm;
  logic [CNT_W-1:0] load_cnt;
  logic             dac_s1, dac_s2, dac_s3, dac_edge;
  logic             wr_last, rd_last, rec_stop;

  assign state    = fsm;
  assign wr_last  = (wr_addr == WR_LAST);
  assign rd_last  = (rd_addr == rec_len - ADDR_W'(1));
  assign rec_stop = key_record || (wav_wren && wr_last);

  // Two-flop synchronizer plus a registered edge flag: rd_req lands three
  // clocks after dac_s1 first sees an LRCLK transition.
  always_ff @(posedge clock_50M or posedge reset) begin
    if (reset) begin
      dac_s1   <= 1'b0;
      dac_s2   <= 1'b0;
      dac_s3   <= 1'b0;
      dac_edge <= 1'b0;
    end else begin
      dac_s1   <= dacclk;
      dac_s2   <= dac_s1;
      dac_s3   <= dac_s2;
      dac_edge <= dac_s2 ^ dac_s3;
    end
  end

  always_ff @(posedge clock_50M or posedge reset) begin
    if (reset) begin
      fsm              <= IDLE;
      load_cnt         <= '0;
      wr_load          <= 1'b0;
      record_start     <= 1'b0;
      voice_write_done <= 1'b0;
      wr_addr          <= '0;
      rd_load          <= 1'b0;
      rd_req           <= 1'b0;
      rd_addr          <= '0;
      rec_len          <= '0;
    end else begin
      voice_write_done <= 1'b0;
      rd_req           <= 1'b0;
      case (fsm)
        IDLE: begin
          if (key_record) begin
            fsm      <= REC_LOAD;
            wr_load  <= 1'b1;
            load_cnt <= '0;
            wr_addr  <= '0;
            rec_len  <= '0;
          end else if (key_play && rec_len != '0) begin
            fsm      <= PLAY_LOAD;
            rd_load  <= 1'b1;
            load_cnt <= '0;
            rd_addr  <= '0;
          end
        end
        REC_LOAD: begin
          load_cnt <= load_cnt + CNT_W'(1);
          if (load_cnt == LOAD_LAST) begin
            wr_load      <= 1'b0;
            record_start <= 1'b1;
            fsm          <= RECORD;
          end
        end
        RECORD: begin
          if (rec_stop) begin
            // A word arriving together with the stop key still belongs to the take.
            rec_len          <= wr_addr + {{(ADDR_W-1){1'b0}}, wav_wren};
            record_start     <= 1'b0;
            voice_write_done <= 1'b1;
            fsm              <= REC_DONE;
          end else if (wav_wren) begin
            wr_addr <= wr_addr + ADDR_W'(1);
          end
        end
        REC_DONE: begin
          fsm <= IDLE;
        end
        PLAY_LOAD: begin
          load_cnt <= load_cnt + CNT_W'(1);
          if (load_cnt == LOAD_LAST) begin
            rd_load <= 1'b0;
            fsm     <= PLAY;
          end
        end
        PLAY: begin
          if (key_play) begin
            fsm <= IDLE;
          end else if (rd_req) begin
            rd_addr <= rd_addr + ADDR_W'(1);
            if (rd_last) fsm <= IDLE;
          end else if (dac_edge) begin
            rd_req <= 1'b1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule
